// File: rtl/spu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// spu_pipe_pkg
//   Shared types and helpers for the SPU data/valid pipeline.
//   - spu_pipe_mode_t : pipeline operating mode (free-running or elastic).
//   - cnt_bits()      : width needed to hold an occupancy of 0..latency,
//                       never less than one bit so LATENCY=0 still has a
//                       legal vector width.
// ---------------------------------------------------------------------------
package spu_pipe_pkg;

    typedef enum int {
        SPU_PIPE_FREE    = 0,
        SPU_PIPE_ELASTIC = 1
    } spu_pipe_mode_t;

    function automatic int cnt_bits(input int latency);
        int b;
        b = $clog2(latency + 1);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/spu_pipe_stage.sv
// ---------------------------------------------------------------------------
// spu_pipe_stage
//   One register stage of the SPU data/valid pipeline: a valid flag and a
//   payload register. Only the valid flag is reset; the payload register is
//   left without reset to keep it cheap.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset (clears valid only)
//   load_i  in   stage takes the upstream valid (and possibly data) this edge
//   gate_i  in   qualifies the data load; tied high when data should follow
//                every load, driven by upstream valid to avoid toggling the
//                payload register on bubbles
//   v_i     in   upstream valid
//   d_i     in   upstream payload
//   v_o     out  stage valid
//   d_o     out  stage payload
// ---------------------------------------------------------------------------
module spu_pipe_stage
    import spu_pipe_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 gate_i,
    input  logic                 v_i,
    input  logic [DATA_BITS-1:0] d_i,
    output logic                 v_o,
    output logic [DATA_BITS-1:0] d_o
);

    logic                 v_q;
    logic [DATA_BITS-1:0] d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
        end else if (load_i) begin
            v_q <= v_i;
        end
    end

    // Payload has no reset on purpose; its value only matters while v_q=1.
    always_ff @(posedge clk) begin
        if (load_i && gate_i) begin
            d_q <= d_i;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/spu_data_valid_pipe.sv
// ---------------------------------------------------------------------------
// spu_data_valid_pipe
//   LATENCY-stage pipeline carrying a payload plus a valid flag, used to
//   balance operator latencies inside the SPU.
//   MODE = SPU_PIPE_FREE    : every stage shifts on each enabled cycle,
//                             m_ready is ignored, s_ready = cke.
//   MODE = SPU_PIPE_ELASTIC : ready/valid backpressure; a stage loads when it
//                             is empty or the stage after it will move, so
//                             bubbles collapse even while the output stalls.
//   LATENCY = 0 gives a combinational pass-through.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset; clears all valid flags
//   cke      in   clock enable; 0 freezes every stage (reset still wins)
//   s_data   in   upstream payload
//   s_valid  in   upstream valid
//   s_ready  out  upstream may transfer this cycle
//   m_data   out  downstream payload (last stage)
//   m_valid  out  downstream valid (last stage)
//   m_ready  in   downstream accepts (elastic mode only)
//   m_count  out  registered number of items held in the pipeline; present
//                 only when SPU_DATA_VALID_PIPE_OCCUPANCY_EN is defined
// ---------------------------------------------------------------------------
module spu_data_valid_pipe
    import spu_pipe_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int DATA_BITS = 8,
    parameter int MODE      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cke,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready
`ifdef SPU_DATA_VALID_PIPE_OCCUPANCY_EN
    ,
    output logic [cnt_bits(LATENCY)-1:0]  m_count
`endif
);

    localparam bit ELASTIC = (MODE == int'(SPU_PIPE_ELASTIC));

    if (LATENCY < 0) begin : g_bad_latency
        $error("spu_data_valid_pipe: LATENCY must be >= 0");
    end

    if ((MODE != int'(SPU_PIPE_FREE)) && (MODE != int'(SPU_PIPE_ELASTIC))) begin : g_bad_mode
        $error("spu_data_valid_pipe: MODE must be 0 or 1");
    end

    // Index 0 is the pipeline input; index LATENCY is the output stage.
    logic [LATENCY:0]     v_chain;
    logic [DATA_BITS-1:0] d_chain [LATENCY+1];
    logic                 ready_in;

    assign v_chain[0] = s_valid;
    assign d_chain[0] = s_data;

    // The ready chain r[k] = !v[k] | r[k+1], r[LATENCY+1] = m_ready, unrolls
    // to "m_ready, or some stage from k to the end is empty". The closed form
    // avoids a self-referencing combinational vector.
    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
        logic rdy;
        logic load;
        logic gate;

        assign rdy  = m_ready | ~(&v_chain[LATENCY:k]);
        assign load = cke & (ELASTIC ? rdy : 1'b1);
        assign gate = ELASTIC ? v_chain[k-1] : 1'b1;

        spu_pipe_stage #(
            .DATA_BITS (DATA_BITS)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .load_i (load),
            .gate_i (gate),
            .v_i    (v_chain[k-1]),
            .d_i    (d_chain[k-1]),
            .v_o    (v_chain[k]),
            .d_o    (d_chain[k])
        );
    end

    if (LATENCY == 0) begin : g_ready_pass
        assign ready_in = m_ready;
    end else begin : g_ready_stages
        assign ready_in = g_stage[1].rdy;
    end

    assign s_ready = cke & (ELASTIC ? ready_in : 1'b1);
    assign m_valid = v_chain[LATENCY];
    assign m_data  = d_chain[LATENCY];

`ifdef SPU_DATA_VALID_PIPE_OCCUPANCY_EN
    localparam int CW = cnt_bits(LATENCY);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_xfer;
    logic          out_xfer;

    // In free mode the last stage is overwritten every enabled cycle, so a
    // valid item there always leaves regardless of m_ready.
    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & cke & (ELASTIC ? m_ready : 1'b1);

    always_comb begin
        count_d = count_q;
        if (in_xfer && !out_xfer) begin
            count_d = count_q + 1'b1;
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign m_count = count_q;
`endif

endmodule
